sniffer_replay_ctrl: RTL and testbench

- Sequences stored test packets from an on-chip packet memory into the ethernet sniffer datapath as an Avalon-ST source (data/valid/sop/eop/ready).
- Configured from the slave CSR bank: packet select, length, repeat count and inter-packet gap.
- Replaces the free-running count-based packet injection with a backpressure-correct, restartable, counted replay engine.

---
 rtl/sniffer_replay_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sniffer_replay_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sniffer_replay_ctrl.sv
// Counted, restartable packet replay engine: streams stored packets from
// packet memory onto an Avalon-ST source through a 2-entry output FIFO.
module sniffer_replay_ctrl #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic [SEL_W-1:0]        cfg_pkt_sel,
    input  logic [ADDR_W:0]         cfg_len_words,
    input  logic [15:0]             cfg_repeat,
    input  logic [7:0]              cfg_gap,
    output logic                    mem_rd_en,
    output logic [SEL_W+ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0]       mem_rdata,
    output logic [WORD_W-1:0]       st_data,
    output logic                    st_valid,
    output logic                    st_sop,
    output logic                    st_eop,
    input  logic                    st_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err_len,
    output logic [15:0]             pkt_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W:0]   len_q;
    logic [15:0]       rep_q;
    logic [7:0]        gap_q;
    logic [ADDR_W:0]   idx_q;
    logic [7:0]        gap_cnt;
    logic              stop_pend;

    logic              rd_q;
    logic              rd_sop_q;
    logic              rd_eop_q;

    logic [WORD_W-1:0] fifo_data [2];
    logic [1:0]        fifo_sop;
    logic [1:0]        fifo_eop;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;

    logic              done_q;
    logic              err_q;
    logic [15:0]       cnt_q;

    logic              push;
    logic              pop;
    logic [1:0]        used;
    logic              rd_en;
    logic              last_idx;
    logic              eop_hs;
    logic [15:0]       cnt_next;
    logic              rep_hit;
    logic              stop_now;
    logic              start_ok;

    assign push     = rd_q;
    assign pop      = st_valid && st_ready;
    // Credit counts the word leaving this cycle so ready=1 sustains 1 word/cycle
    assign used     = occ + {1'b0, rd_q} - {1'b0, pop};
    assign rd_en    = (state == S_STREAM) && (used < 2'd2);
    assign last_idx = (idx_q == len_q - IDX_ONE);
    assign eop_hs   = pop && st_eop;
    assign cnt_next = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign rep_hit  = (rep_q != 16'd0) && (cnt_next == rep_q);
    assign stop_now = stop_pend || cfg_stop;
    assign start_ok = (cfg_len_words != '0) && (cfg_len_words <= MAX_LEN);

    assign mem_rd_en = rd_en;
    assign mem_addr  = {sel_q, idx_q[ADDR_W-1:0]};
    assign st_valid  = (occ != 2'd0);
    assign st_data   = fifo_data[rd_ptr];
    assign st_sop    = st_valid && fifo_sop[rd_ptr];
    assign st_eop    = st_valid && fifo_eop[rd_ptr];
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign err_len   = err_q;
    assign pkt_count = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            sel_q     <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
            rd_q      <= 1'b0;
            rd_sop_q  <= 1'b0;
            rd_eop_q  <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
            fifo_sop  <= '0;
            fifo_eop  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rd_q     <= rd_en;
            rd_sop_q <= (idx_q == '0);
            rd_eop_q <= last_idx;

            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_sop[wr_ptr]  <= rd_sop_q;
                fifo_eop[wr_ptr]  <= rd_eop_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};

            if (rd_en) idx_q <= idx_q + IDX_ONE;
            if (cfg_stop && state != S_IDLE) stop_pend <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (start_ok) begin
                            sel_q     <= cfg_pkt_sel;
                            len_q     <= cfg_len_words;
                            rep_q     <= cfg_repeat;
                            gap_q     <= cfg_gap;
                            cnt_q     <= '0;
                            done_q    <= 1'b0;
                            err_q     <= 1'b0;
                            idx_q     <= '0;
                            stop_pend <= 1'b0;
                            state     <= S_STREAM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (rd_en && last_idx) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (eop_hs) begin
                        cnt_q <= cnt_next;
                        idx_q <= '0;
                        if (stop_now || rep_hit) begin
                            done_q    <= 1'b1;
                            stop_pend <= 1'b0;
                            state     <= S_IDLE;
                        end else if (gap_q == 8'd0) begin
                            state <= S_STREAM;
                        end else begin
                            gap_cnt <= gap_q;
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (stop_now) begin
                        done_q    <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= S_IDLE;
                    end else if (gap_cnt == 8'd1) begin
                        state <= S_STREAM;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sniffer_replay_ctrl.sv
// Directed bench for sniffer_replay_ctrl: replay, backpressure, repeat/gap,
// stop, illegal length and mid-packet reset.
module tb_sniffer_replay_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cfg_start;
    logic        cfg_stop;
    logic [1:0]  cfg_pkt_sel;
    logic [8:0]  cfg_len_words;
    logic [15:0] cfg_repeat;
    logic [7:0]  cfg_gap;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_sop;
    logic        st_eop;
    logic        st_ready;
    logic        busy;
    logic        done;
    logic        err_len;
    logic [15:0] pkt_count;

    sniffer_replay_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_pkt_sel  (cfg_pkt_sel),
        .cfg_len_words(cfg_len_words),
        .cfg_repeat   (cfg_repeat),
        .cfg_gap      (cfg_gap),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .st_data      (st_data),
        .st_valid     (st_valid),
        .st_sop       (st_sop),
        .st_eop       (st_eop),
        .st_ready     (st_ready),
        .busy         (busy),
        .done         (done),
        .err_len      (err_len),
        .pkt_count    (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet memory: word content encodes its own address
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= 32'hA000_0000 | {22'd0, mem_addr};
    end

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int outst = 0;
    int max_outst = 0;
    int stall_viol = 0;
    int stall_seen = 0;
    int first_valid = -1;

    logic [31:0] rd_log [$];
    int          rd_cyc [$];
    logic [31:0] hs_data [$];
    logic        hs_sop [$];
    logic        hs_eop [$];
    int          hs_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic        hold;
        logic [31:0] held;
        hold = st_valid && !st_ready;
        held = st_data;
        if (reset_n) begin
            if (mem_rd_en) begin
                rd_log.push_back({22'd0, mem_addr});
                rd_cyc.push_back(cycle);
                outst++;
            end
            if (st_valid && st_ready) begin
                hs_data.push_back(st_data);
                hs_sop.push_back(st_sop);
                hs_eop.push_back(st_eop);
                hs_cyc.push_back(cycle);
                outst--;
            end
            if (st_valid && first_valid < 0) first_valid = cycle;
            if (hold) stall_seen++;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (outst > max_outst) max_outst = outst;
        if (hold && reset_n && (!st_valid || st_data !== held))
            stall_viol++;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        rd_cyc.delete();
        hs_data.delete();
        hs_sop.delete();
        hs_eop.delete();
        hs_cyc.delete();
        outst       = 0;
        max_outst   = 0;
        stall_viol  = 0;
        stall_seen  = 0;
        first_valid = -1;
    endtask

    task automatic start(input logic [1:0] sel, input logic [8:0] len,
                         input logic [15:0] rep, input logic [7:0] gap);
        cfg_pkt_sel   = sel;
        cfg_len_words = len;
        cfg_repeat    = rep;
        cfg_gap       = gap;
        cfg_start     = 1'b1;
        cyc();
        cfg_start     = 1'b0;
    endtask

    task automatic run_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            cyc();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        int s0;
        int k;
        int n;
        bit stop_sent;

        reset_n       = 1'b0;
        cfg_start     = 1'b0;
        cfg_stop      = 1'b0;
        cfg_pkt_sel   = '0;
        cfg_len_words = '0;
        cfg_repeat    = '0;
        cfg_gap       = '0;
        st_ready      = 1'b1;
        repeat (3) cyc();
        chk("rst_valid", {31'd0, st_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err_len}, 32'd0);
        chk("rst_cnt", {16'd0, pkt_count}, 32'd0);
        chk("rst_rd", {31'd0, mem_rd_en}, 32'd0);
        reset_n = 1'b1;
        cyc();

        // Single packet, sel=1 len=4
        clear_logs();
        start(2'd1, 9'd4, 16'd1, 8'd0);
        s0 = cycle;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        run_idle("t1_timeout", 50);
        chk("t1_nrd", rd_log.size(), 32'd4);
        for (int i = 0; i < rd_log.size(); i++) begin
            chk("t1_addr", rd_log[i], 32'h100 + i);
            chk("t1_rdcyc", rd_cyc[i], s0 + i);
        end
        chk("t1_lat", first_valid, s0 + 2);
        chk("t1_nwords", hs_data.size(), 32'd4);
        for (int i = 0; i < hs_data.size(); i++) begin
            chk("t1_data", hs_data[i], 32'hA000_0100 + i);
            chk("t1_sop", {31'd0, hs_sop[i]}, {31'd0, i == 0});
            chk("t1_eop", {31'd0, hs_eop[i]}, {31'd0, i == 3});
        end
        if (hs_cyc.size() == 4) chk("t1_busyfall", cycle, hs_cyc[3] + 1);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_cnt", {16'd0, pkt_count}, 32'd1);

        // Backpressure, ready pattern 1,0,0,1
        clear_logs();
        start(2'd2, 9'd5, 16'd1, 8'd0);
        k = 0;
        while (busy && k < 200) begin
            st_ready = (k % 4 == 0) || (k % 4 == 3);
            cyc();
            k++;
        end
        st_ready = 1'b1;
        chk("t2_timeout", {31'd0, busy}, 32'd0);
        chk("t2_nwords", hs_data.size(), 32'd5);
        for (int i = 0; i < hs_data.size(); i++) begin
            chk("t2_data", hs_data[i], 32'hA000_0200 + i);
            chk("t2_sop", {31'd0, hs_sop[i]}, {31'd0, i == 0});
            chk("t2_eop", {31'd0, hs_eop[i]}, {31'd0, i == 4});
        end
        chk("t2_maxout", {31'd0, max_outst <= 2}, 32'd1);
        chk("t2_stalled", {31'd0, stall_seen > 0}, 32'd1);
        chk("t2_hold", stall_viol, 32'd0);
        chk("t2_done", {31'd0, done}, 32'd1);

        // Repeat 3, len 1, gap 4
        clear_logs();
        start(2'd3, 9'd1, 16'd3, 8'd4);
        run_idle("t3_timeout", 200);
        chk("t3_nwords", hs_data.size(), 32'd3);
        for (int i = 0; i < hs_data.size(); i++) begin
            chk("t3_data", hs_data[i], 32'hA000_0300);
            chk("t3_sop", {31'd0, hs_sop[i]}, 32'd1);
            chk("t3_eop", {31'd0, hs_eop[i]}, 32'd1);
        end
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("t3_gap", hs_cyc[i] - hs_cyc[i-1], 32'd7);
        chk("t3_cnt", {16'd0, pkt_count}, 32'd3);
        chk("t3_done", {31'd0, done}, 32'd1);

        // Continuous, stop on word 3 of packet 2
        clear_logs();
        start(2'd0, 9'd8, 16'd0, 8'd0);
        stop_sent = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            if (!stop_sent && pkt_count == 16'd1 && st_valid && st_ready
                && st_data[7:0] == 8'd3) begin
                cfg_stop  = 1'b1;
                stop_sent = 1'b1;
            end
            cyc();
            cfg_stop = 1'b0;
            n++;
        end
        chk("t4_timeout", {31'd0, busy}, 32'd0);
        chk("t4_stopsent", {31'd0, stop_sent}, 32'd1);
        repeat (5) cyc();
        chk("t4_cnt", {16'd0, pkt_count}, 32'd2);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_nwords", hs_data.size(), 32'd16);
        chk("t4_nrd", rd_log.size(), 32'd16);
        if (hs_data.size() == 16) begin
            chk("t4_lastdata", hs_data[15], 32'hA000_0007);
            chk("t4_lasteop", {31'd0, hs_eop[15]}, 32'd1);
        end

        // Illegal lengths, then a legal start
        clear_logs();
        start(2'd1, 9'd0, 16'd1, 8'd0);
        chk("t5_err0", {31'd0, err_len}, 32'd1);
        chk("t5_busy0", {31'd0, busy}, 32'd0);
        start(2'd1, 9'd257, 16'd1, 8'd0);
        chk("t5_err257", {31'd0, err_len}, 32'd1);
        chk("t5_busy257", {31'd0, busy}, 32'd0);
        repeat (3) cyc();
        chk("t5_nrd", rd_log.size(), 32'd0);
        start(2'd1, 9'd2, 16'd1, 8'd0);
        chk("t5_errclr", {31'd0, err_len}, 32'd0);
        run_idle("t5_timeout", 50);
        chk("t5_nwords", hs_data.size(), 32'd2);
        chk("t5_cnt", {16'd0, pkt_count}, 32'd1);

        // Reset mid-packet, then replay from word 0
        clear_logs();
        start(2'd2, 9'd6, 16'd1, 8'd0);
        n = 0;
        while (hs_data.size() < 2 && n < 50) begin
            cyc();
            n++;
        end
        chk("t6_reach", hs_data.size(), 32'd2);
        reset_n = 1'b0;
        cyc();
        chk("t6_valid", {31'd0, st_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_cnt", {16'd0, pkt_count}, 32'd0);
        chk("t6_rd", {31'd0, mem_rd_en}, 32'd0);
        reset_n = 1'b1;
        cyc();
        clear_logs();
        start(2'd2, 9'd6, 16'd1, 8'd0);
        run_idle("t6_timeout", 50);
        chk("t6_nwords", hs_data.size(), 32'd6);
        if (hs_data.size() == 6) begin
            chk("t6_first", hs_data[0], 32'hA000_0200);
            chk("t6_sop", {31'd0, hs_sop[0]}, 32'd1);
            chk("t6_last", hs_data[5], 32'hA000_0205);
            chk("t6_eop", {31'd0, hs_eop[5]}, 32'd1);
        end
        chk("t6_done", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
